// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths and state encodings shared by the MEM stage
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int MS_TO_WS_BUS_WD = 70;

    // IDLE: stage empty; WAIT: load issued, response not yet seen; DONE: result ready
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

endpackage

// File: rtl/ms_resp_buf.sv
// rtl/ms_resp_buf.sv - load-response capture register and final_result mux
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   resp_hit       response accepted this cycle (WAIT & data_ok)
//   rdata          SRAM load data
//   is_load        current instruction is a load
//   alu_result     ALU result of the current instruction
//   final_result   result forwarded to WB and to the ID bypass
module ms_resp_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         resp_hit,
    input  logic [W-1:0] rdata,
    input  logic         is_load,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] final_result
);

    logic [W-1:0] rdata_buf;

    // Captured on every accepted response so that a WB stall cannot lose it;
    // when WB is ready the same cycle the live data is used directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf <= '0;
        end else if (resp_hit) begin
            rdata_buf <= rdata;
        end
    end

    always_comb begin
        if (resp_hit) begin
            final_result = rdata;
        end else if (is_load) begin
            final_result = rdata_buf;
        end else begin
            final_result = alu_result;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with variable-latency load response
//
// Optional feature macro: MS_PERF_CNT_EN (adds ms_stall_cnt stall counter).
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   ws_allowin         WB can accept
//   ms_allowin         MEM can accept
//   es_to_ms_valid/bus EXE payload {res_from_mem,gr_we,dest,alu_result,pc}
//   ms_to_ws_valid/bus WB payload {gr_we,dest,final_result,pc}
//   data_sram_rdata    load data, qualified by data_sram_data_ok
//   data_sram_data_ok  load response strobe
//   ms_load_wait       load outstanding, ID must stall on dest match
//   ms_to_ds_result    final_result for bypass
//   MS_dest            dest gated by stage valid
//   ms_stall_cnt       cycles held with no output (MS_PERF_CNT_EN only)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef MS_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    input  logic                       data_sram_data_ok,
    output logic                       ms_load_wait,
    output logic [DATA_W-1:0]          ms_to_ds_result,
    output logic [4:0]                 MS_dest
`ifdef MS_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]           ms_stall_cnt
`endif
);

    ms_state_t state, state_next;

    logic              ms_valid;
    logic              resp_hit;
    logic              ms_ready_go;
    logic              accept;
    ms_state_t         entry_state;

    logic              res_from_mem;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] alu_result;
    logic [31:0]       pc;
    logic [DATA_W-1:0] final_result;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= MS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake / output logic
    always_comb begin
        ms_valid       = (state != MS_IDLE);
        resp_hit       = (state == MS_WAIT) && data_sram_data_ok;
        ms_ready_go    = (state == MS_DONE) || resp_hit;
        ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go;
        ms_load_wait   = ms_valid && (state == MS_WAIT) && !data_sram_data_ok;
        MS_dest        = dest & {5{ms_valid}};
        accept         = es_to_ms_valid && ms_allowin;
        entry_state    = es_to_ms_bus[70] ? MS_WAIT : MS_DONE;
    end

    // Next state: a retiring entry frees the stage, and a new accept in the
    // same cycle takes its place directly so back-to-back traffic has no bubble.
    always_comb begin
        state_next = state;
        case (state)
            MS_IDLE: begin
                if (accept) state_next = entry_state;
            end
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    if (!ws_allowin)  state_next = MS_DONE;
                    else if (accept)  state_next = entry_state;
                    else              state_next = MS_IDLE;
                end
            end
            MS_DONE: begin
                if (ws_allowin) state_next = accept ? entry_state : MS_IDLE;
            end
            default: state_next = MS_IDLE;
        endcase
    end

    // Payload is qualified by state, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            res_from_mem <= es_to_ms_bus[70];
            gr_we        <= es_to_ms_bus[69];
            dest         <= es_to_ms_bus[68:64];
            alu_result   <= es_to_ms_bus[63:32];
            pc           <= es_to_ms_bus[31:0];
        end
    end

    ms_resp_buf #(.W(DATA_W)) u_resp_buf (
        .clk          (clk),
        .resetn       (resetn),
        .resp_hit     (resp_hit),
        .rdata        (data_sram_rdata),
        .is_load      (res_from_mem),
        .alu_result   (alu_result),
        .final_result (final_result)
    );

    assign ms_to_ws_bus    = {gr_we, dest, final_result, pc};
    assign ms_to_ds_result = final_result;

`ifdef MS_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_stall_cnt <= '0;
        end else if (ms_valid && !ms_to_ws_valid) begin
            ms_stall_cnt <= ms_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic        ms_load_wait;
    logic [31:0] ms_to_ds_result;
    logic [4:0]  MS_dest;
`ifdef MS_PERF_CNT_EN
    logic [31:0] ms_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .ms_load_wait      (ms_load_wait),
        .ms_to_ds_result   (ms_to_ds_result),
        .MS_dest           (MS_dest)
`ifdef MS_PERF_CNT_EN
        ,
        .ms_stall_cnt      (ms_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_retired = 0;
    int n_pushed = 0;
    logic [69:0] exp_q[$];

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every WB handshake pops the oldest expected entry
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            n_retired++;
            if (exp_q.size() > 0) begin
                check("retire_bus", ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    // Present one instruction; returns just after the accepting edge
    task automatic send(input bit ld, input logic [4:0] d, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] exp_res, input bit push);
        int n;
        es_to_ms_bus   = {ld, 1'b1, d, alu, pc};
        es_to_ms_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ms_allowin && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ms_allowin) check("send_timeout", {69'd0, ms_allowin}, 70'd1);
        if (push) begin
            exp_q.push_back({1'b1, d, exp_res, pc});
            n_pushed++;
        end
        @(posedge clk);
        #1 es_to_ms_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    logic [31:0] rd_vals[5];

    initial begin
        resetn            = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_rdata   = '0;
        data_sram_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_to_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        check("rst_allowin",     {69'd0, ms_allowin},     70'd1);
        check("rst_ms_dest",     {65'd0, MS_dest},        70'd0);
        check("rst_load_wait",   {69'd0, ms_load_wait},   70'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // 1: ALU op, single-cycle latency
        data_sram_data_ok = 1'b1;
        send(1'b0, 5'd5, 32'h1234, 32'h100, 32'h1234, 1'b1);
        @(negedge clk);
        check("alu_valid",  {69'd0, ms_to_ws_valid},  70'd1);
        check("alu_dest",   {65'd0, MS_dest},         70'd5);
        check("alu_bypass", {38'd0, ms_to_ds_result}, 70'h1234);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("alu_empty", {69'd0, ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;

        // 2: load with 3-cycle response delay
        data_sram_data_ok = 1'b0;
        send(1'b1, 5'd7, 32'hAAAA, 32'h200, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_wait",       {69'd0, ms_load_wait},   70'd1);
            check("ld_allowin",    {69'd0, ms_allowin},     70'd0);
            check("ld_no_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
            @(posedge clk);
            #1;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        check("ld_resp_valid", {69'd0, ms_to_ws_valid},  70'd1);
        check("ld_resp_wait",  {69'd0, ms_load_wait},    70'd0);
        check("ld_resp_byp",   {38'd0, ms_to_ds_result}, {38'd0, 32'hDEADBEEF});
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;

        // 3: response arrives while WB stalls; must be buffered
        ws_allowin = 1'b0;
        send(1'b1, 5'd9, 32'hBBBB, 32'h300, 32'hDEADBEEF, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        check("stall_valid0", {69'd0, ms_to_ws_valid}, 70'd1);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BADF00D;
        @(negedge clk);
        check("stall_valid1", {69'd0, ms_to_ws_valid},  70'd1);
        check("stall_buf",    {38'd0, ms_to_ds_result}, {38'd0, 32'hDEADBEEF});
        check("stall_allow",  {69'd0, ms_allowin},      70'd0);
        @(posedge clk);
        #1 ws_allowin = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_once", {69'd0, ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;

        // 4: back-to-back loads, response every cycle
        for (int i = 0; i < 5; i++) rd_vals[i] = $urandom;
        data_sram_data_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            es_to_ms_valid  = 1'b1;
            es_to_ms_bus    = {1'b1, 1'b1, 5'(10 + i), 32'hC000 + 32'(i), 32'h400 + 32'(4 * i)};
            data_sram_rdata = (i > 0) ? rd_vals[i-1] : 32'h0;
            exp_q.push_back({1'b1, 5'(10 + i), rd_vals[i], 32'h400 + 32'(4 * i)});
            n_pushed++;
            @(negedge clk);
            check("b2b_allowin", {69'd0, ms_allowin}, 70'd1);
            if (i > 0) check("b2b_retire", {69'd0, ms_to_ws_valid}, 70'd1);
            @(posedge clk);
            #1;
        end
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rd_vals[4];
        @(negedge clk);
        check("b2b_last", {69'd0, ms_to_ws_valid}, 70'd1);
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;

        // 5: reset mid-WAIT, stray response afterwards
        send(1'b1, 5'd20, 32'hDDDD, 32'h500, 32'h0, 1'b0);
        @(negedge clk);
        check("rst_wait_pending", {69'd0, ms_load_wait}, 70'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
        #2 check("rst_mid_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555AAAA;
        @(negedge clk);
        check("stray_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
        check("stray_allowin", {69'd0, ms_allowin},     70'd1);
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("stray_after", {69'd0, ms_to_ws_valid}, 70'd0);
        @(posedge clk);
        #1;

`ifdef MS_PERF_CNT_EN
        // 6: stall counter
        do_reset();
        send(1'b1, 5'd3, 32'h0, 32'h600, 32'h11112222, 1'b1);
        repeat (4) @(posedge clk);
        #1 data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11112222;
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("perf_4", {38'd0, ms_stall_cnt}, 70'd4);
        send(1'b1, 5'd4, 32'h0, 32'h604, 32'h33334444, 1'b1);
        repeat (2) @(posedge clk);
        #1 data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h33334444;
        @(posedge clk);
        #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("perf_6", {38'd0, ms_stall_cnt}, 70'd6);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty",   70'(exp_q.size()), 70'd0);
        check("retire_cnt", 70'(n_retired),    70'(n_pushed));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
